// File: rtl/aes_pkg.sv
// Shared AES constants, FSM encoding and GF(2^8) helpers used by the S-box lanes.
package aes_pkg;

   localparam int   AES_STATE_W = 128;
   localparam int   AES_BYTES   = 16;
   localparam logic AES_ENC     = 1'b1;
   localparam logic AES_DEC     = 1'b0;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } aes_fsm_e;

   // Multiply in GF(2^8) modulo x^8+x^4+x^3+x+1.
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = 8'h00;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // x^254 gives the multiplicative inverse, with 0 mapping to 0.
   function automatic logic [7:0] gf_inv(input logic [7:0] x);
      logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252;
      x2   = gf_mul(x, x);
      x3   = gf_mul(x2, x);
      x6   = gf_mul(x3, x3);
      x12  = gf_mul(x6, x6);
      x15  = gf_mul(x12, x3);
      x30  = gf_mul(x15, x15);
      x60  = gf_mul(x30, x30);
      x120 = gf_mul(x60, x60);
      x240 = gf_mul(x120, x120);
      x252 = gf_mul(x240, x12);
      return gf_mul(x252, x2);
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
      return 8'((x << n) | (x >> (8 - n)));
   endfunction

   function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
      logic [7:0] b;
      b = gf_inv(x);
      return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
   endfunction

   function automatic logic [7:0] sbox_inv(input logic [7:0] x);
      return gf_inv(rotl8(x, 1) ^ rotl8(x, 3) ^ rotl8(x, 6) ^ 8'h05);
   endfunction

endpackage

// File: rtl/aes_sbox_canright_verified.sv
// Single-byte S-box lane: forward S-box when enc_dec is high, inverse S-box otherwise.
module aes_sbox_canright_verified
   import aes_pkg::*;
(
   input  logic [7:0] data_in,
   input  logic       enc_dec,
   output logic [7:0] data_out
);

   always_comb begin
      if (enc_dec == AES_ENC) data_out = sbox_fwd(data_in);
      else                    data_out = sbox_inv(data_in);
   end

endmodule

// File: rtl/aes_subbytes_folded.sv
// Folded SubBytes over a 128-bit state: NUM_SBOX byte lanes per beat, 16/NUM_SBOX beats,
// optional register after the lanes, result published only once the whole state is done.
module aes_subbytes_folded
   import aes_pkg::*;
#(
   parameter int NUM_SBOX   = 4,
   parameter int PIPE_STAGE = 0
)
(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_state,
   input  logic         in_enc_dec,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_state,
   output logic         out_enc_dec,
   output logic         busy
);

   localparam int BEATS  = (NUM_SBOX > 0) ? AES_BYTES / NUM_SBOX : 1;
   localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int LANE_W = NUM_SBOX * 8;

   generate
      if (!(NUM_SBOX == 1 || NUM_SBOX == 2 || NUM_SBOX == 4 || NUM_SBOX == 8 || NUM_SBOX == 16))
      begin : g_bad_num_sbox
         $error("aes_subbytes_folded: NUM_SBOX must be 1, 2, 4, 8 or 16");
      end
      if (!(PIPE_STAGE == 0 || PIPE_STAGE == 1)) begin : g_bad_pipe
         $error("aes_subbytes_folded: PIPE_STAGE must be 0 or 1");
      end
   endgenerate

   aes_fsm_e                r_fsm, w_fsm_nxt;
   logic [CNT_W-1:0]        r_cnt;
   logic [AES_STATE_W-1:0]  r_src, r_res, r_out;
   logic                    r_mode, r_out_mode, r_drain_q;
   logic                    w_accept, w_last, w_drain_end;
   logic [7:0]              w_lo;
   logic [LANE_W-1:0]       w_lane_in, w_lane_out;
   logic                    w_wr_en;
   logic [7:0]              w_wr_lo;
   logic [LANE_W-1:0]       w_wr_data;

   assign in_ready    = (r_fsm == ST_IDLE) | ((r_fsm == ST_DONE) & out_ready);
   assign w_accept    = in_valid & in_ready;
   assign w_last      = (r_cnt == CNT_W'(BEATS - 1));
   assign w_drain_end = (PIPE_STAGE == 0) | r_drain_q;
   // Beat k covers bytes k*NUM_SBOX.. ; byte 0 is the MSB, so slices walk down from the top.
   assign w_lo        = 8'((BEATS - 1 - int'(r_cnt)) * LANE_W);
   assign w_lane_in   = r_src[w_lo +: LANE_W];

   assign out_valid   = (r_fsm == ST_DONE);
   assign out_state   = r_out;
   assign out_enc_dec = r_out_mode;
   assign busy        = (r_fsm != ST_IDLE);

   genvar gi;
   generate
      for (gi = 0; gi < NUM_SBOX; gi++) begin : g_lane
         aes_sbox_canright_verified u_sbox (
            .data_in  (w_lane_in[(NUM_SBOX-1-gi)*8 +: 8]),
            .enc_dec  (r_mode),
            .data_out (w_lane_out[(NUM_SBOX-1-gi)*8 +: 8])
         );
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_fsm <= ST_IDLE;
      else        r_fsm <= w_fsm_nxt;
   end

   always_comb begin
      w_fsm_nxt = r_fsm;
      case (r_fsm)
         ST_IDLE:  if (w_accept) w_fsm_nxt = ST_RUN;
         ST_RUN:   if (w_last) w_fsm_nxt = ST_DRAIN;
         ST_DRAIN: if (w_drain_end) w_fsm_nxt = ST_DONE;
         ST_DONE:  if (out_ready) w_fsm_nxt = w_accept ? ST_RUN : ST_IDLE;
         default:  w_fsm_nxt = ST_IDLE;
      endcase
   end

   // DRAIN is the commit cycle; with the lane register it spends one extra cycle landing the last beat.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt     <= '0;
         r_drain_q <= 1'b0;
      end else begin
         r_drain_q <= (r_fsm == ST_DRAIN) & ~r_drain_q & (PIPE_STAGE != 0);
         if (w_accept)              r_cnt <= '0;
         else if (r_fsm == ST_RUN)  r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
      end
   end

   generate
      if (PIPE_STAGE != 0) begin : g_pipe
         logic [LANE_W-1:0] r_lane_q;
         logic [7:0]        r_q_lo;
         logic              r_q_vld;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_lane_q <= '0;
               r_q_lo   <= '0;
               r_q_vld  <= 1'b0;
            end else begin
               r_q_vld <= (r_fsm == ST_RUN);
               if (r_fsm == ST_RUN) begin
                  r_lane_q <= w_lane_out;
                  r_q_lo   <= w_lo;
               end
            end
         end

         assign w_wr_en   = r_q_vld;
         assign w_wr_lo   = r_q_lo;
         assign w_wr_data = r_lane_q;
      end else begin : g_direct
         assign w_wr_en   = (r_fsm == ST_RUN);
         assign w_wr_lo   = w_lo;
         assign w_wr_data = w_lane_out;
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_src      <= '0;
         r_mode     <= 1'b0;
         r_res      <= '0;
         r_out      <= '0;
         r_out_mode <= 1'b0;
      end else begin
         if (w_accept) begin
            r_src  <= in_state;
            r_mode <= in_enc_dec;
         end
         if (w_wr_en) r_res[w_wr_lo +: LANE_W] <= w_wr_data;
         if ((r_fsm == ST_DRAIN) && w_drain_end) begin
            r_out      <= r_res;
            r_out_mode <= r_mode;
         end
      end
   end

endmodule

// File: tb/tb_aes_subbytes_folded.sv
// Bench for aes_subbytes_folded: known-answer table through a scoreboard, back-pressure,
// mode freezing, mid-run reset and a NUM_SBOX/PIPE_STAGE latency sweep.
module tb_aes_subbytes_folded;

   localparam int NCFG = 9;

   typedef struct {
      logic [127:0] din;
      logic         mode;
      logic [127:0] dout;
   } vec_t;

   typedef struct {
      logic [127:0] st;
      logic         mode;
   } exp_t;

   localparam logic [127:0] RAMP   = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] RAMP_S = 128'h638293c31bfc33f5c4eeacea4bc12816;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid, in_ready, in_enc_dec;
   logic [127:0] in_state;
   logic         out_valid, out_ready, out_enc_dec, busy;
   logic [127:0] out_state;

   logic              sw_in_valid, sw_mode, sw_out_ready;
   logic [127:0]      sw_state;
   logic [NCFG-1:0]   sw_in_ready, sw_out_valid, sw_out_enc, sw_busy;
   logic [127:0]      sw_out_state [NCFG];

   int   total = 0;
   int   bad   = 0;
   exp_t sb_q[$];
   exp_t mon_e;
   vec_t vecs[8];

   always #5 clk = ~clk;

   function automatic int cfg_n(input int g);
      case (g)
         0, 1:    return 1;
         2, 3:    return 2;
         4, 5:    return 8;
         6, 7:    return 16;
         default: return 4;
      endcase
   endfunction

   function automatic int cfg_p(input int g);
      return ((g % 2) == 1 || g == 8) ? 1 : 0;
   endfunction

   aes_subbytes_folded #(.NUM_SBOX(4), .PIPE_STAGE(0)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_state(in_state), .in_enc_dec(in_enc_dec),
      .out_valid(out_valid), .out_ready(out_ready), .out_state(out_state),
      .out_enc_dec(out_enc_dec), .busy(busy)
   );

   genvar g;
   generate
      for (g = 0; g < NCFG; g++) begin : g_sw
         aes_subbytes_folded #(.NUM_SBOX(cfg_n(g)), .PIPE_STAGE(cfg_p(g))) u_sw (
            .clk(clk), .rst_n(rst_n),
            .in_valid(sw_in_valid), .in_ready(sw_in_ready[g]), .in_state(sw_state),
            .in_enc_dec(sw_mode), .out_valid(sw_out_valid[g]), .out_ready(sw_out_ready),
            .out_state(sw_out_state[g]), .out_enc_dec(sw_out_enc[g]), .busy(sw_busy[g])
         );
      end
   endgenerate

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // Scoreboard: every output handshake pops the oldest expected result.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (sb_q.size() == 0) begin
            chk("unexpected_output", out_state, 128'hx);
         end else begin
            mon_e = sb_q.pop_front();
            chk("out_state", out_state, mon_e.st);
            chk("out_enc_dec", 128'(out_enc_dec), 128'(mon_e.mode));
         end
      end
   end

   task automatic send(input logic [127:0] st, input logic md, input logic [127:0] ex);
      bit ok;
      exp_t e;
      in_state = st; in_enc_dec = md; in_valid = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 100 && !ok; i++) begin
         @(negedge clk);
         if (in_ready) ok = 1'b1;
      end
      if (!ok) chk("accept_timeout", 128'(0), 128'(1));
      else begin
         e.st = ex; e.mode = md;
         sb_q.push_back(e);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   // Call right after the accept edge; counts edges until out_valid is seen.
   task automatic measure_lat(input int exp_lat);
      int lat;
      lat = 0;
      do begin
         @(posedge clk); lat++;
         @(negedge clk);
      end while (!out_valid && lat < 40);
      chk("latency", 128'(lat), 128'(exp_lat));
   endtask

   task automatic drain_sb();
      for (int i = 0; i < 200 && sb_q.size() != 0; i++) @(posedge clk);
      if (sb_q.size() != 0) chk("drain_timeout", 128'(sb_q.size()), 128'(0));
      @(posedge clk); #1;
   endtask

   task automatic sweep(input logic [127:0] st, input logic [127:0] ex);
      int lat[NCFG];
      for (int k = 0; k < NCFG; k++) lat[k] = 0;
      sw_out_ready = 1'b0; sw_state = st; sw_mode = 1'b1; sw_in_valid = 1'b1;
      @(negedge clk);
      chk("sw_in_ready", 128'(sw_in_ready), 128'({NCFG{1'b1}}));
      @(posedge clk); #1;
      sw_in_valid = 1'b0;
      for (int c = 1; c <= 25; c++) begin
         @(posedge clk); @(negedge clk);
         for (int k = 0; k < NCFG; k++)
            if (lat[k] == 0 && sw_out_valid[k]) lat[k] = c;
      end
      for (int k = 0; k < NCFG; k++) begin
         chk($sformatf("sw_latency_n%0d_p%0d", cfg_n(k), cfg_p(k)), 128'(lat[k]),
             128'(16 / cfg_n(k) + cfg_p(k) + 1));
         chk($sformatf("sw_state_n%0d_p%0d", cfg_n(k), cfg_p(k)), sw_out_state[k], ex);
         chk($sformatf("sw_mode_n%0d_p%0d", cfg_n(k), cfg_p(k)), 128'(sw_out_enc[k]), 128'(1));
      end
      @(posedge clk); #1 sw_out_ready = 1'b1;
      @(posedge clk); #1 sw_out_ready = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{128'h0,           1'b1, {16{8'h63}}};
      vecs[1] = '{RAMP,             1'b1, RAMP_S};
      vecs[2] = '{RAMP_S,           1'b0, RAMP};
      vecs[3] = '{{16{8'h53}},      1'b1, {16{8'hed}}};
      vecs[4] = '{{16{8'hff}},      1'b1, {16{8'h16}}};
      vecs[5] = '{{16{8'h63}},      1'b0, 128'h0};
      vecs[6] = '{{16{8'h16}},      1'b0, {16{8'hff}}};
      vecs[7] = '{{16{8'h01}},      1'b1, {16{8'h7c}}};

      rst_n = 1'b0; in_valid = 1'b0; in_state = '0; in_enc_dec = 1'b0; out_ready = 1'b1;
      sw_in_valid = 1'b0; sw_state = '0; sw_mode = 1'b0; sw_out_ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready", 128'(in_ready), 128'(1));
      chk("rst_out_valid", 128'(out_valid), 128'(0));
      chk("rst_out_state", out_state, 128'h0);
      chk("rst_out_enc_dec", 128'(out_enc_dec), 128'(0));
      chk("rst_busy", 128'(busy), 128'(0));
      @(posedge clk); #1 rst_n = 1'b1;
      @(posedge clk); #1;

      // Known-answer table, each with a latency check
      for (int i = 0; i < 8; i++) begin
         send(vecs[i].din, vecs[i].mode, vecs[i].dout);
         measure_lat(5);
         drain_sb();
      end

      // Mode is frozen at accept: wiggle in_enc_dec during RUN
      send(RAMP_S, 1'b0, RAMP);
      in_enc_dec = 1'b1;
      @(posedge clk); #1 in_enc_dec = 1'b0;
      @(posedge clk); #1 in_enc_dec = 1'b1;
      drain_sb();
      in_enc_dec = 1'b0;

      // Back-pressure then back-to-back accept on release
      out_ready = 1'b0;
      send(128'h0, 1'b1, {16{8'h63}});
      measure_lat(5);
      in_state = RAMP; in_enc_dec = 1'b1; in_valid = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); @(negedge clk);
         chk("bp_out_state", out_state, {16{8'h63}});
         chk("bp_in_ready", 128'(in_ready), 128'(0));
         chk("bp_out_valid", 128'(out_valid), 128'(1));
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      begin
         exp_t e;
         e.st = RAMP_S; e.mode = 1'b1;
         sb_q.push_back(e);
      end
      @(negedge clk);
      chk("b2b_in_ready", 128'(in_ready), 128'(1));
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("b2b_busy", 128'(busy), 128'(1));
      chk("b2b_out_valid", 128'(out_valid), 128'(0));
      measure_lat(5);
      drain_sb();

      // Reset in the middle of RUN (beat 2)
      send(RAMP, 1'b1, RAMP_S);
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_out_valid", 128'(out_valid), 128'(0));
      chk("mid_rst_busy", 128'(busy), 128'(0));
      chk("mid_rst_in_ready", 128'(in_ready), 128'(1));
      chk("mid_rst_out_state", out_state, 128'h0);
      sb_q.delete();
      @(posedge clk); #1 rst_n = 1'b1;
      @(posedge clk); #1;
      send({16{8'h53}}, 1'b1, {16{8'hed}});
      measure_lat(5);
      drain_sb();

      // Parameter sweep
      sweep(128'h0, {16{8'h63}});
      sweep(RAMP, RAMP_S);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
